// File: rtl/std_div_stream_pkg.sv
// std_div_stream_pkg: FSM state encoding shared by the streaming divider.
package std_div_stream_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/std_div_stream_fifo.sv
// std_div_stream_fifo: operand FIFO with registered full/empty flags.
module std_div_stream_fifo #(
    parameter int DW    = 64,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          full_q, full_d, empty_q, empty_d;
    logic          do_push, do_pop;

    always_comb begin
        do_push = push && !full_q;
        do_pop  = pop && !empty_q;
        wr_d    = wr_q + AW'(do_push);
        rd_d    = rd_q + AW'(do_pop);
        cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        full_d  = cnt_d == (AW+1)'(DEPTH);
        empty_d = cnt_d == '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

    assign dout  = mem_q[rd_q];
    assign full  = full_q;
    assign empty = empty_q;
endmodule

// File: rtl/std_div_stream.sv
// std_div_stream: valid/ready unsigned divider, one restoring step per cycle behind an operand FIFO.
module std_div_stream
    import std_div_stream_pkg::*;
#(
    parameter int width = 32,
    parameter int depth = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] left,
    input  logic [width-1:0] right,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] out_quotient,
    output logic [width-1:0] out_remainder
);
    localparam int CW = $clog2(width);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [width-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [width-1:0]   rq_q, rq_d, rr_q, rr_d;
    logic               ov_q, ov_d;
    logic [2*width-1:0] head;
    logic               empty, full, pop, ok;
    logic [width:0]     shifted;

    std_div_stream_fifo #(.DW(2*width), .DEPTH(depth)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_valid),
        .din   ({left, right}),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // quo_q holds the unconsumed dividend bits and collects quotient bits from the LSB
    always_comb begin
        shifted = {rem_q, quo_q[width-1]};
        ok      = shifted >= {1'b0, dvs_q};
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        rq_d    = rq_q;
        rr_d    = rr_q;
        ov_d    = ov_q && !out_ready;
        pop     = 1'b0;
        case (state_q)
            IDLE: if (!empty) begin
                pop     = 1'b1;
                rem_d   = '0;
                quo_d   = head[2*width-1:width];
                dvs_d   = head[width-1:0];
                cnt_d   = CW'(width-1);
                state_d = CALC;
            end
            CALC: begin
                rem_d   = ok ? width'(shifted - {1'b0, dvs_q}) : shifted[width-1:0];
                quo_d   = {quo_q[width-2:0], ok};
                cnt_d   = cnt_q == '0 ? '0 : cnt_q - CW'(1);
                state_d = cnt_q == '0 ? DONE : CALC;
            end
            DONE: if (!ov_q || out_ready) begin
                rq_d    = quo_q;
                rr_d    = rem_q;
                ov_d    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            rq_q    <= '0;
            rr_q    <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            rq_q    <= rq_d;
            rr_q    <= rr_d;
            ov_q    <= ov_d;
        end
    end

    assign in_ready      = !full;
    assign out_valid     = ov_q;
    assign out_quotient  = rq_q;
    assign out_remainder = rr_q;
endmodule

// File: tb/tb_std_div_stream.sv
// tb_std_div_stream: scoreboard bench for the streaming divider at width 8, depth 2.
module tb_std_div_stream;
    localparam int W = 8;
    localparam int D = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] left = '0;
    logic [W-1:0] right = '0;
    logic         in_ready, out_valid;
    logic [W-1:0] out_quotient, out_remainder;

    int checks = 0;
    int failures = 0;
    int n_acc = 0;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] got_q[$];

    std_div_stream #(.width(W), .depth(D)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .left          (left),
        .right         (right),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] model(input logic [W-1:0] l, input logic [W-1:0] r);
        return r == 0 ? {{W{1'b1}}, l} : {l / r, l % r};
    endfunction

    // handshakes are sampled mid-cycle, the edge follows, inputs change 1 after it
    task automatic cycle();
        @(negedge clk);
        if (in_valid && in_ready) begin
            exp_q.push_back(model(left, right));
            n_acc++;
        end
        if (out_valid && out_ready) got_q.push_back({out_quotient, out_remainder});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
        checks++; if (out_quotient !== '0) begin failures++; $display("FAIL reset_quotient got %0d expected 0", out_quotient); end
        checks++; if (out_remainder !== '0) begin failures++; $display("FAIL reset_remainder got %0d expected 0", out_remainder); end
        reset = 1'b1;
        cycle();
    endtask

    task automatic test_op(input string name, input logic [W-1:0] l, input logic [W-1:0] r,
                           input logic [W-1:0] eq, input logic [W-1:0] er);
        int n, a;
        out_ready = 1'b1;
        left = l;
        right = r;
        in_valid = 1'b1;
        a = n_acc;
        cycle();
        in_valid = 1'b0;
        checks++; if (n_acc !== a + 1) begin failures++; $display("FAIL %s_accept got %0d expected %0d", name, n_acc - a, 1); end
        n = 0;
        while (!out_valid && n < 40) begin
            cycle();
            n++;
        end
        checks++; if (n !== 10) begin failures++; $display("FAIL %s_latency got %0d expected 10", name, n); end
        checks++; if ({out_quotient, out_remainder} !== {eq, er}) begin
            failures++; $display("FAIL %s_result got q=%0d r=%0d expected q=%0d r=%0d", name, out_quotient, out_remainder, eq, er);
        end
        cycle();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL %s_drop got %b expected 0", name, out_valid); end
        checks++; if (got_q.size() !== 1 || got_q[0] !== {eq, er}) begin
            failures++; $display("FAIL %s_transfer got %0d items expected 1 matching q=%0d r=%0d", name, got_q.size(), eq, er);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_single();
        test_op("single", 8'd200, 8'd7, 8'd28, 8'd4);
    endtask

    task automatic test_div_zero();
        test_op("div_zero", 8'd55, 8'd0, 8'd255, 8'd55);
    endtask

    task automatic test_boundaries();
        test_op("max_by_one", 8'd255, 8'd1, 8'd255, 8'd0);
        test_op("small_by_max", 8'd3, 8'd255, 8'd0, 8'd3);
    endtask

    task automatic test_backpressure();
        logic [W-1:0] bl [6];
        logic [W-1:0] br [6];
        logic [2*W-1:0] hq, e, g;
        int idx, a, a0, bound;
        logic stable;
        bl = '{8'd100, 8'd250, 8'd17, 8'd81, 8'd200, 8'd7};
        br = '{8'd3, 8'd9, 8'd0, 8'd9, 8'd13, 8'd8};
        out_ready = 1'b0;
        idx = 0;
        a0 = n_acc;
        left = bl[0];
        right = br[0];
        in_valid = 1'b1;
        repeat (60) begin
            a = n_acc;
            cycle();
            if (n_acc != a) begin
                idx++;
                if (idx < 6) begin left = bl[idx]; right = br[idx]; end else in_valid = 1'b0;
            end
        end
        checks++; if (n_acc - a0 !== 4) begin failures++; $display("FAIL bp_accepted got %0d expected 4", n_acc - a0); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got %b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid got %b expected 1", out_valid); end
        checks++; if ({out_quotient, out_remainder} !== model(bl[0], br[0])) begin
            failures++; $display("FAIL bp_first got %h expected %h", {out_quotient, out_remainder}, model(bl[0], br[0]));
        end
        hq = {out_quotient, out_remainder};
        stable = 1'b1;
        repeat (20) begin
            cycle();
            if ({out_quotient, out_remainder} !== hq || out_valid !== 1'b1) stable = 1'b0;
        end
        checks++; if (stable !== 1'b1) begin failures++; $display("FAIL bp_hold got %b expected 1", stable); end
        out_ready = 1'b1;
        bound = 0;
        while (got_q.size() < 6 && bound < 300) begin
            a = n_acc;
            cycle();
            if (n_acc != a) begin
                idx++;
                if (idx < 6) begin left = bl[idx]; right = br[idx]; end else in_valid = 1'b0;
            end
            bound++;
        end
        in_valid = 1'b0;
        checks++; if (got_q.size() !== 6) begin failures++; $display("FAIL bp_drained got %0d expected 6", got_q.size()); end
        checks++; if (n_acc - a0 !== 6) begin failures++; $display("FAIL bp_total_accepted got %0d expected 6", n_acc - a0); end
        for (int i = 0; i < 6 && got_q.size() > 0 && exp_q.size() > 0; i++) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++; if (g !== e || e !== model(bl[i], br[i])) begin
                failures++; $display("FAIL bp_order[%0d] got %h expected %h", i, g, model(bl[i], br[i]));
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_streaming();
        logic [2*W-1:0] e, g;
        int idx, a, c;
        idx = 0;
        c = 0;
        left = W'($urandom_range(0, 255));
        right = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
        while (got_q.size() < 100 && c < 6000) begin
            in_valid = (idx < 100) && ($urandom_range(0, 1) == 1);
            out_ready = $urandom_range(0, 3) != 0;
            a = n_acc;
            cycle();
            if (n_acc != a) begin
                idx++;
                left = W'($urandom_range(0, 255));
                right = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
            end
            c++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++; if (got_q.size() !== 100 || exp_q.size() !== 100) begin
            failures++; $display("FAIL stream_count got %0d results for %0d accepted expected 100", got_q.size(), exp_q.size());
        end
        for (int i = 0; got_q.size() > 0 && exp_q.size() > 0; i++) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++; if (g !== e) begin failures++; $display("FAIL stream[%0d] got %h expected %h", i, g, e); end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int a, c;
        out_ready = 1'b1;
        left = 8'd90;
        right = 8'd4;
        in_valid = 1'b1;
        a = n_acc;
        c = 0;
        while (n_acc - a < 3 && c < 20) begin
            cycle();
            left = left + 8'd1;
            c++;
        end
        in_valid = 1'b0;
        repeat (3) cycle();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_full got %b expected 0", in_ready); end
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_out_valid got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_in_ready got %b expected 1", in_ready); end
        exp_q.delete();
        got_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        cycle();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_idle got %b expected 0", out_valid); end
        test_op("after_reset", 8'd100, 8'd9, 8'd11, 8'd1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_div_zero();
        test_boundaries();
        test_backpressure();
        test_streaming();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
